// File: rtl/adr_seq_pkg.sv
// Shared types and helpers for the adr_seq_gen address sequencer.
// The end-swap helper is only used when ADR_SEQ_SWAP_EN is defined.
package adr_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } adr_seq_state_t;

  localparam int unsigned ADR_W_DEF = 4;

  // Exchange bit w-1 and bit 0 of v, leaving the middle bits in place.
  function automatic logic [31:0] adr_swap_ends(input logic [31:0] v, input int unsigned w);
    logic [31:0] r;
    r        = v;
    r[w-1]   = v[0];
    r[0]     = v[w-1];
    return r;
  endfunction

endpackage

// File: rtl/adr_seq_cnt.sv
// Loadable up-counter with enable and a terminal-value compare.
// Used for both the address counter and the pass counter.
module adr_seq_cnt #(
  parameter int unsigned   W        = 4,
  parameter logic [W-1:0]  RST_VAL  = '0,
  parameter logic [W-1:0]  TERM_VAL = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic [W-1:0] q,
  output logic         at_term
);

  assign at_term = (q == TERM_VAL);

  // Reset wins, then load, then count; otherwise hold.
  always_ff @(posedge clk) begin
    if (rst) begin
      q <= RST_VAL;
    end else if (load) begin
      q <= load_val;
    end else if (en) begin
      q <= q + W'(1);
    end
  end

endmodule

// File: rtl/adr_seq_gen.sv
// Address sequencer: walks ADR_FIRST..ADR_LAST for PASSES passes under a
// valid/ready handshake and pulses done once per completed sequence.
// Optional ADR_SEQ_SWAP_EN: drive adr with its MSB and LSB exchanged.
module adr_seq_gen
  import adr_seq_pkg::*;
#(
  parameter int unsigned ADR_W     = ADR_W_DEF,
  parameter int unsigned ADR_FIRST = 0,
  parameter int unsigned ADR_LAST  = 15,
  parameter int unsigned PASSES    = 1,
  parameter int unsigned PASS_W    = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic              adr_rdy,
  output logic [ADR_W-1:0]  adr,
  output logic              adr_vld,
  output logic              busy,
  output logic              done,
  output logic [PASS_W-1:0] pass_cnt
);

  if (ADR_FIRST > ADR_LAST || ADR_LAST >= (2**ADR_W)) begin : g_bad_window
    $error("adr_seq_gen: require ADR_FIRST <= ADR_LAST < 2**ADR_W");
  end
  if (PASSES < 1 || PASSES > (2**PASS_W)) begin : g_bad_passes
    $error("adr_seq_gen: require 1 <= PASSES <= 2**PASS_W");
  end

  adr_seq_state_t state, state_nxt;

  logic [ADR_W-1:0]  adr_q;
  logic              adr_term, adr_load, adr_en;
  logic              pass_term, pass_load, pass_en;
  logic              hs;

  assign hs = adr_vld & adr_rdy;

  adr_seq_cnt #(
    .W        (ADR_W),
    .RST_VAL  (ADR_W'(ADR_FIRST)),
    .TERM_VAL (ADR_W'(ADR_LAST))
  ) u_adr_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (adr_load),
    .load_val (ADR_W'(ADR_FIRST)),
    .en       (adr_en),
    .q        (adr_q),
    .at_term  (adr_term)
  );

  adr_seq_cnt #(
    .W        (PASS_W),
    .RST_VAL  ('0),
    .TERM_VAL (PASS_W'(PASSES - 1))
  ) u_pass_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (pass_load),
    .load_val ('0),
    .en       (pass_en),
    .q        (pass_cnt),
    .at_term  (pass_term)
  );

`ifdef ADR_SEQ_SWAP_EN
  assign adr = ADR_W'(adr_swap_ends(32'(adr_q), ADR_W));
`else
  assign adr = adr_q;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state and counter control; counters sit at their start values outside RUN.
  always_comb begin
    state_nxt = state;
    adr_load  = 1'b0;
    adr_en    = 1'b0;
    pass_load = 1'b0;
    pass_en   = 1'b0;
    case (state)
      IDLE: begin
        adr_load  = 1'b1;
        pass_load = 1'b1;
        if (start && !abort) begin
          state_nxt = RUN;
        end
      end
      RUN: begin
        if (abort) begin
          state_nxt = IDLE;
          adr_load  = 1'b1;
          pass_load = 1'b1;
        end else if (hs) begin
          if (!adr_term) begin
            adr_en = 1'b1;
          end else if (!pass_term) begin
            adr_load = 1'b1;
            pass_en  = 1'b1;
          end else begin
            state_nxt = DONE;
            adr_load  = 1'b1;
            pass_load = 1'b1;
          end
        end
      end
      DONE: begin
        state_nxt = IDLE;
        adr_load  = 1'b1;
        pass_load = 1'b1;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Status outputs registered from the next state so they line up with it.
  always_ff @(posedge clk) begin
    if (rst) begin
      adr_vld <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      adr_vld <= (state_nxt == RUN);
      busy    <= (state_nxt == RUN);
      done    <= (state_nxt == DONE);
    end
  end

endmodule

// File: tb/tb_adr_seq_gen.sv
// Bench for adr_seq_gen: a default instance (0..15, 1 pass) and a multi-pass
// instance (2..4, 3 passes) share inputs and are checked every cycle against
// a handshake-count model of each.
module tb_adr_seq_gen;

  localparam int P_IDLE = 0;
  localparam int P_RUN  = 1;
  localparam int P_DONE = 2;

  logic       clk = 1'b0;
  logic       rst, start, abort, adr_rdy;
  logic [3:0] adr0, adr1, pc0, pc1;
  logic       vld0, vld1, busy0, busy1, done0, done1;

  int errors = 0;
  int checks = 0;

  int mFirst[2]  = '{0, 2};
  int mLast[2]   = '{15, 4};
  int mPasses[2] = '{1, 3};
  int mPhase[2];
  int mK[2];
  int hsCnt1;

  always #5 clk = ~clk;

  adr_seq_gen u_dut0 (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .abort    (abort),
    .adr_rdy  (adr_rdy),
    .adr      (adr0),
    .adr_vld  (vld0),
    .busy     (busy0),
    .done     (done0),
    .pass_cnt (pc0)
  );

  adr_seq_gen #(
    .ADR_FIRST (2),
    .ADR_LAST  (4),
    .PASSES    (3)
  ) u_dut1 (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .abort    (abort),
    .adr_rdy  (adr_rdy),
    .adr      (adr1),
    .adr_vld  (vld1),
    .busy     (busy1),
    .done     (done1),
    .pass_cnt (pc1)
  );

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [3:0] expAdr(input int i);
    logic [3:0] v;
    int len;
    len = mLast[i] - mFirst[i] + 1;
    if (mPhase[i] == P_RUN) v = 4'(mFirst[i] + (mK[i] % len));
    else                    v = 4'(mFirst[i]);
`ifdef ADR_SEQ_SWAP_EN
    v = {v[0], v[2:1], v[3]};
`endif
    return v;
  endfunction

  function automatic logic [3:0] expPass(input int i);
    int len;
    len = mLast[i] - mFirst[i] + 1;
    if (mPhase[i] == P_RUN) return 4'(mK[i] / len);
    return 4'd0;
  endfunction

  // Advance one instance's model by one clock using the inputs held across the edge.
  task automatic modelStep(input int i);
    int total;
    total = (mLast[i] - mFirst[i] + 1) * mPasses[i];
    if (rst) begin
      mPhase[i] = P_IDLE;
      mK[i]     = 0;
    end else begin
      case (mPhase[i])
        P_IDLE: if (start && !abort) begin
          mPhase[i] = P_RUN;
          mK[i]     = 0;
        end
        P_RUN: begin
          if (abort) begin
            mPhase[i] = P_IDLE;
            mK[i]     = 0;
          end else if (adr_rdy) begin
            mK[i]++;
            if (mK[i] == total) begin
              mPhase[i] = P_DONE;
              mK[i]     = 0;
            end
          end
        end
        default: mPhase[i] = P_IDLE;
      endcase
    end
  endtask

  task automatic checkInst(input int i, input logic [3:0] a, input logic v, input logic b,
                           input logic d, input logic [3:0] p);
    checkOutput($sformatf("adr%0d", i),  a, expAdr(i));
    checkOutput($sformatf("vld%0d", i),  v, mPhase[i] == P_RUN);
    checkOutput($sformatf("busy%0d", i), b, mPhase[i] == P_RUN);
    checkOutput($sformatf("done%0d", i), d, mPhase[i] == P_DONE);
    checkOutput($sformatf("pass%0d", i), p, expPass(i));
  endtask

  task automatic applyStimulus(input logic s, input logic a, input logic r, input logic rs);
    start   = s;
    abort   = a;
    adr_rdy = r;
    rst     = rs;
    #1;
    if (rs || (vld1 && a)) hsCnt1 = 0;
    else if (vld1 && r) hsCnt1++;
    @(posedge clk);
    modelStep(0);
    modelStep(1);
    #1;
    checkInst(0, adr0, vld0, busy0, done0, pc0);
    checkInst(1, adr1, vld1, busy1, done1, pc1);
    if (mPhase[1] == P_DONE) begin
      checkOutput("hs1", 32'(hsCnt1), 32'd9);
      hsCnt1 = 0;
    end
  endtask

  initial begin
    mPhase = '{P_IDLE, P_IDLE};
    mK     = '{0, 0};
    hsCnt1 = 0;
    start = 1'b0; abort = 1'b0; adr_rdy = 1'b0; rst = 1'b1;
    @(negedge clk);

    // Reset state.
    applyStimulus(0, 0, 0, 1);
    applyStimulus(0, 0, 0, 1);
    applyStimulus(0, 0, 1, 0);

    // Single pass with adr_rdy held high; also covers the multi-pass walk.
    applyStimulus(1, 0, 1, 0);
    for (int c = 0; c < 20; c++) applyStimulus(0, 0, 1, 0);

    // Backpressure at adr=7, with start held during RUN (ignored).
    applyStimulus(1, 0, 1, 0);
    for (int c = 0; c < 7; c++) applyStimulus(1, 0, 1, 0);
    for (int c = 0; c < 3; c++) applyStimulus(0, 0, 0, 0);
    for (int c = 0; c < 10; c++) applyStimulus(0, 0, 1, 0);
    applyStimulus(1, 0, 1, 0);
    applyStimulus(0, 0, 1, 0);
    for (int c = 0; c < 4; c++) applyStimulus(0, 0, 1, 0);

    // Abort at adr=9, then start and abort together in IDLE.
    applyStimulus(1, 0, 1, 0);
    for (int c = 0; c < 9; c++) applyStimulus(0, 0, 1, 0);
    applyStimulus(0, 1, 1, 0);
    applyStimulus(1, 1, 1, 0);
    applyStimulus(0, 0, 1, 0);

    // Reset in the middle of RUN at adr=5.
    applyStimulus(1, 0, 1, 0);
    for (int c = 0; c < 5; c++) applyStimulus(0, 0, 1, 0);
    applyStimulus(0, 0, 1, 1);
    applyStimulus(0, 0, 1, 0);

    // Randomized traffic.
    for (int c = 0; c < 1500; c++) begin
      applyStimulus(($urandom_range(0, 7) == 0),
                    ($urandom_range(0, 31) == 0),
                    ($urandom_range(0, 9) < 7),
                    ($urandom_range(0, 199) == 0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
